ace_snoop_initiator: RTL and testbench
======================================

Name: ace_snoop_initiator

Overview:
- Interconnect-side initiator for the ACE snoop channels (AC/CR/CD).
- Accepts one snoop request at a time from a local valid/ready port and drives AC (acaddr, acsnoop, acprot).
- Collects the CR response and, when CR signals data transfer, the full cache line on CD.
- Returns the response and line data to the requester; the bench uses it in place of hand-toggled acvalid/acsnoop so snooped masters get protocol-correct traffic.

Parameters:
- ADDR_WIDTH, 44, width of acaddr and req_addr.
- CD_DATA_WIDTH, 128, width of one CD beat.
- LINE_BEATS, 4, CD beats per cache line (64 B line at 128 b).
- TIMEOUT, 1024, cycles allowed in any wait state before abort; 0 disables the timeout.

Ports:
- clk_100MHz  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  snoop request valid.
- req_ready  out  1  request accepted when req_valid & req_ready.
- req_addr  in  ADDR_WIDTH  snoop address.
- req_snoop  in  4  ACSNOOP code.
- req_prot  in  3  ACPROT.
- acvalid  out  1  AC valid.
- acready  in  1  AC ready.
- acaddr  out  ADDR_WIDTH  AC address.
- acsnoop  out  4  AC snoop type.
- acprot  out  3  AC protection.
- crvalid  in  1  CR valid.
- crready  out  1  CR ready.
- crresp  in  5  CR response: [0] DataTransfer, [1] Error, [2] PassDirty, [3] IsShared, [4] WasUnique.
- cdvalid  in  1  CD valid.
- cdready  out  1  CD ready.
- cddata  in  CD_DATA_WIDTH  CD beat.
- cdlast  in  1  CD last beat.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  result consumed.
- rsp_crresp  out  5  captured crresp.
- rsp_data  out  LINE_BEATS*CD_DATA_WIDTH  line data, beat 0 in the LSBs.
- rsp_has_data  out  1  line data valid.
- rsp_err  out  2  error code: 0 ok, 1 timeout, 2 cdlast mismatch.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (asynchronous): state IDLE; all valid/ready outputs 0 except req_ready=1; acaddr, acsnoop, acprot, rsp_* and the timeout counter all 0.
- IDLE: req_ready=1. On handshake, register addr/snoop/prot into the AC outputs, assert acvalid next cycle, go to AC_SEND, req_ready=0.
- AC_SEND: acvalid held high and AC payload held stable until acready. On acvalid&acready: acvalid=0 next cycle, go to CR_WAIT.
- CR_WAIT: crready=1. On crvalid, capture crresp.
  - If crresp[0]=1: go to CD_RECV with beat counter 0.
  - Otherwise: go to RESP with rsp_has_data=0.
- CD_RECV: cdready=1. Each cdvalid beat is written into slot beat_cnt of the line buffer and beat_cnt increments.
  - cdlast is expected exactly on beat LINE_BEATS-1.
  - cdlast early, or absent on the final beat: rsp_err=2; the FSM keeps accepting beats until cdlast, and beats beyond LINE_BEATS are discarded (counter saturates).
  - After cdlast: go to RESP, rsp_has_data=1.
- RESP: rsp_valid=1, all rsp_* stable until rsp_ready. Then IDLE; req_ready rises the following cycle (no same-cycle back-to-back accept).
- Timeout: counter cleared on every state entry, increments each cycle in AC_SEND, CR_WAIT and CD_RECV.
  - On reaching TIMEOUT: drop acvalid/crready/cdready, set rsp_err=1, go to RESP.
  - rsp_crresp keeps whatever was captured (0 if CR never arrived).
- Handshakes are single-cycle: no combinational path from any input to any valid/ready output except through state registers.
- crvalid in states other than CR_WAIT and cdvalid outside CD_RECV are ignored (their ready signals are 0).
- Reset mid-transaction: immediate return to IDLE; any partially collected line is discarded.
- Latency without wait states: req handshake → acvalid 1 cycle; AC handshake → crready already high; CR with no data → rsp_valid 1 cycle after CR handshake.

Decomposition:
- Shared package ace_snoop_pkg holds:
  - ACSNOOP codes: ReadOnce 4'b0000, ReadShared 4'b0001, ReadClean 4'b0010, ReadNotSharedDirty 4'b0011, ReadUnique 4'b0111, CleanShared 4'b1000, CleanInvalid 4'b1001, MakeInvalid 4'b1101.
  - CRRESP bit-position constants.
  - FSM state enum {IDLE, AC_SEND, CR_WAIT, CD_RECV, RESP}.
  - rsp_err code constants.
- One natural sub-module, snoop_line_buffer: beat counter plus LINE_BEATS x CD_DATA_WIDTH register file with write-enable, clear, and a saturated/overflow flag.

Test Plan:
- ReadOnce, addr 0x002, acready high, crresp=5'b00000 → AC handshake 1 cycle after req; rsp_valid with rsp_crresp=0, rsp_has_data=0, rsp_err=0.
- ReadShared, addr 0x40, crresp=5'b01001, 4 CD beats 0x..01 to 0x..04 with cdlast on beat 3 → rsp_data = {beat3,beat2,beat1,beat0}, rsp_has_data=1, rsp_err=0.
- acready held low 5 cycles → acvalid, acaddr and acsnoop stable for all 5 cycles; transaction then completes normally.
- TIMEOUT=16, crvalid never asserted → rsp_err=1 after 16 cycles in CR_WAIT, crready drops, rsp_crresp=0; next request accepted.
- crresp[0]=1, cdlast on beat 1 → rsp_err=2, rsp_has_data=1; beats 0-1 captured, others 0.
- reset pulsed during CD_RECV beat 2 → all outputs at reset values immediately; a fresh CleanInvalid request completes with rsp_err=0.

Source files
------------

// File: rtl/ace_snoop_pkg.sv
// Shared ACE snoop definitions: ACSNOOP codes, CRRESP bit positions, FSM states and error codes.
package ace_snoop_pkg;

    localparam logic [3:0] SNP_READ_ONCE             = 4'b0000;
    localparam logic [3:0] SNP_READ_SHARED           = 4'b0001;
    localparam logic [3:0] SNP_READ_CLEAN            = 4'b0010;
    localparam logic [3:0] SNP_READ_NOT_SHARED_DIRTY = 4'b0011;
    localparam logic [3:0] SNP_READ_UNIQUE           = 4'b0111;
    localparam logic [3:0] SNP_CLEAN_SHARED          = 4'b1000;
    localparam logic [3:0] SNP_CLEAN_INVALID         = 4'b1001;
    localparam logic [3:0] SNP_MAKE_INVALID          = 4'b1101;

    localparam int unsigned CR_DATA_TRANSFER = 0;
    localparam int unsigned CR_ERROR         = 1;
    localparam int unsigned CR_PASS_DIRTY    = 2;
    localparam int unsigned CR_IS_SHARED     = 3;
    localparam int unsigned CR_WAS_UNIQUE    = 4;

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_CDLAST  = 2'd2;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        AC_SEND = 3'd1,
        CR_WAIT = 3'd2,
        CD_RECV = 3'd3,
        RESP    = 3'd4
    } snoop_state_e;

    // States in which the abort timer runs.
    function automatic logic is_wait_state(snoop_state_e s);
        return (s == AC_SEND) || (s == CR_WAIT) || (s == CD_RECV);
    endfunction

endpackage

// File: rtl/snoop_line_buffer.sv
// Cache-line collector: saturating beat counter plus LINE_BEATS x CD_DATA_WIDTH register file.
module snoop_line_buffer #(
    parameter  int unsigned CD_DATA_WIDTH = 128,
    parameter  int unsigned LINE_BEATS    = 4,
    localparam int unsigned BEAT_W        = $clog2(LINE_BEATS + 1),
    localparam int unsigned LINE_W        = LINE_BEATS * CD_DATA_WIDTH
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clr_i,
    input  logic                     we_i,
    input  logic [CD_DATA_WIDTH-1:0] data_i,
    output logic [BEAT_W-1:0]        beat_cnt_o,
    output logic                     sat_o,
    output logic [LINE_W-1:0]        line_o
);

    logic [BEAT_W-1:0] cnt_q, cnt_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic              sat;

    assign sat = (cnt_q == BEAT_W'(LINE_BEATS));

    // Beats past the end of the line are dropped once the counter saturates.
    always_comb begin
        cnt_d  = cnt_q;
        line_d = line_q;
        if (clr_i) begin
            cnt_d  = '0;
            line_d = '0;
        end else if (we_i && !sat) begin
            for (int unsigned b = 0; b < LINE_BEATS; b++) begin
                if (cnt_q == BEAT_W'(b)) begin
                    line_d[b*CD_DATA_WIDTH +: CD_DATA_WIDTH] = data_i;
                end
            end
            cnt_d = cnt_q + BEAT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            line_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            line_q <= line_d;
        end
    end

    assign beat_cnt_o = cnt_q;
    assign sat_o      = sat;
    assign line_o     = line_q;

endmodule

// File: rtl/ace_snoop_initiator.sv
// ACE snoop initiator: issues one AC request, collects CR and optional CD line, returns the result.
module ace_snoop_initiator
    import ace_snoop_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH    = 44,
    parameter int unsigned CD_DATA_WIDTH = 128,
    parameter int unsigned LINE_BEATS    = 4,
    parameter int unsigned TIMEOUT       = 1024
) (
    input  logic                                clk_100MHz,
    input  logic                                reset,
    input  logic                                req_valid,
    output logic                                req_ready,
    input  logic [ADDR_WIDTH-1:0]               req_addr,
    input  logic [3:0]                          req_snoop,
    input  logic [2:0]                          req_prot,
    output logic                                acvalid,
    input  logic                                acready,
    output logic [ADDR_WIDTH-1:0]               acaddr,
    output logic [3:0]                          acsnoop,
    output logic [2:0]                          acprot,
    input  logic                                crvalid,
    output logic                                crready,
    input  logic [4:0]                          crresp,
    input  logic                                cdvalid,
    output logic                                cdready,
    input  logic [CD_DATA_WIDTH-1:0]            cddata,
    input  logic                                cdlast,
    output logic                                rsp_valid,
    input  logic                                rsp_ready,
    output logic [4:0]                          rsp_crresp,
    output logic [LINE_BEATS*CD_DATA_WIDTH-1:0] rsp_data,
    output logic                                rsp_has_data,
    output logic [1:0]                          rsp_err,
    output logic                                busy
);

    localparam int unsigned TMR_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned BEAT_W   = $clog2(LINE_BEATS + 1);
    localparam logic [BEAT_W-1:0] LAST_IDX = BEAT_W'(LINE_BEATS - 1);

    snoop_state_e state_q, state_d;

    logic [TMR_W-1:0]      tmr_q, tmr_d;
    logic [ADDR_WIDTH-1:0] acaddr_q, acaddr_d;
    logic [3:0]            acsnoop_q, acsnoop_d;
    logic [2:0]            acprot_q, acprot_d;
    logic [4:0]            rsp_crresp_q, rsp_crresp_d;
    logic                  rsp_has_data_q, rsp_has_data_d;
    logic [1:0]            rsp_err_q, rsp_err_d;
    logic                  req_ready_q, req_ready_d;
    logic                  acvalid_q, acvalid_d;
    logic                  crready_q, crready_d;
    logic                  cdready_q, cdready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  busy_q, busy_d;

    logic                  req_fire, ac_fire, cr_fire, cd_fire, rsp_fire;
    logic                  tmr_hit, abort, cd_mismatch, buf_clr;
    logic [BEAT_W-1:0]     buf_cnt;
    logic                  buf_sat;

    // Handshakes only ever see registered ready/valid, so no input reaches them combinationally.
    assign req_fire = req_valid & req_ready_q;
    assign ac_fire  = acvalid_q & acready;
    assign cr_fire  = crvalid & crready_q;
    assign cd_fire  = cdvalid & cdready_q;
    assign rsp_fire = rsp_valid_q & rsp_ready;

    assign tmr_hit = (TIMEOUT != 0) && (tmr_q == TMR_W'(TIMEOUT - 1));

    assign cd_mismatch = cdlast ? (buf_sat || (buf_cnt != LAST_IDX)) : (buf_cnt == LAST_IDX);

    // A handshake landing on the final timer cycle still wins over the abort.
    always_comb begin
        abort = 1'b0;
        if (tmr_hit) begin
            unique case (state_q)
                AC_SEND: abort = !ac_fire;
                CR_WAIT: abort = !cr_fire;
                CD_RECV: abort = !(cd_fire && cdlast);
                default: abort = 1'b0;
            endcase
        end
    end

    snoop_line_buffer #(
        .CD_DATA_WIDTH (CD_DATA_WIDTH),
        .LINE_BEATS    (LINE_BEATS)
    ) u_line_buf (
        .clk_i      (clk_100MHz),
        .rst_i      (reset),
        .clr_i      (buf_clr),
        .we_i       (cd_fire),
        .data_i     (cddata),
        .beat_cnt_o (buf_cnt),
        .sat_o      (buf_sat),
        .line_o     (rsp_data)
    );

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req_fire) state_d = AC_SEND;
            end
            AC_SEND: begin
                if (ac_fire)    state_d = CR_WAIT;
                else if (abort) state_d = RESP;
            end
            CR_WAIT: begin
                if (cr_fire)    state_d = crresp[CR_DATA_TRANSFER] ? CD_RECV : RESP;
                else if (abort) state_d = RESP;
            end
            CD_RECV: begin
                if ((cd_fire && cdlast) || abort) state_d = RESP;
            end
            RESP: begin
                if (rsp_fire) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state and latched, keeping every valid/ready a flop.
    always_comb begin
        req_ready_d    = (state_d == IDLE);
        acvalid_d      = (state_d == AC_SEND);
        crready_d      = (state_d == CR_WAIT);
        cdready_d      = (state_d == CD_RECV);
        rsp_valid_d    = (state_d == RESP);
        busy_d         = (state_d != IDLE);
        acaddr_d       = acaddr_q;
        acsnoop_d      = acsnoop_q;
        acprot_d       = acprot_q;
        rsp_crresp_d   = rsp_crresp_q;
        rsp_has_data_d = rsp_has_data_q;
        rsp_err_d      = rsp_err_q;
        buf_clr        = 1'b0;
        tmr_d          = '0;

        if ((state_d == state_q) && is_wait_state(state_q)) begin
            tmr_d = tmr_q + TMR_W'(1);
        end

        if (req_fire) begin
            acaddr_d       = req_addr;
            acsnoop_d      = req_snoop;
            acprot_d       = req_prot;
            rsp_crresp_d   = '0;
            rsp_has_data_d = 1'b0;
            rsp_err_d      = ERR_OK;
            buf_clr        = 1'b1;
        end

        if (cr_fire) begin
            rsp_crresp_d = crresp;
        end

        if (cd_fire) begin
            if (cd_mismatch) rsp_err_d = ERR_CDLAST;
            if (cdlast)      rsp_has_data_d = 1'b1;
        end

        if (abort) begin
            rsp_err_d = ERR_TIMEOUT;
        end
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            tmr_q          <= '0;
            acaddr_q       <= '0;
            acsnoop_q      <= '0;
            acprot_q       <= '0;
            rsp_crresp_q   <= '0;
            rsp_has_data_q <= 1'b0;
            rsp_err_q      <= ERR_OK;
            req_ready_q    <= 1'b1;
            acvalid_q      <= 1'b0;
            crready_q      <= 1'b0;
            cdready_q      <= 1'b0;
            rsp_valid_q    <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            tmr_q          <= tmr_d;
            acaddr_q       <= acaddr_d;
            acsnoop_q      <= acsnoop_d;
            acprot_q       <= acprot_d;
            rsp_crresp_q   <= rsp_crresp_d;
            rsp_has_data_q <= rsp_has_data_d;
            rsp_err_q      <= rsp_err_d;
            req_ready_q    <= req_ready_d;
            acvalid_q      <= acvalid_d;
            crready_q      <= crready_d;
            cdready_q      <= cdready_d;
            rsp_valid_q    <= rsp_valid_d;
            busy_q         <= busy_d;
        end
    end

    assign req_ready    = req_ready_q;
    assign acvalid      = acvalid_q;
    assign acaddr       = acaddr_q;
    assign acsnoop      = acsnoop_q;
    assign acprot       = acprot_q;
    assign crready      = crready_q;
    assign cdready      = cdready_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_crresp   = rsp_crresp_q;
    assign rsp_has_data = rsp_has_data_q;
    assign rsp_err      = rsp_err_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_ace_snoop_initiator.sv
// Directed bench for ace_snoop_initiator with hand-computed expectations per scenario.
module tb_ace_snoop_initiator;

    logic         clk_100MHz = 1'b0;
    logic         reset;
    logic         req_valid;
    logic         req_ready;
    logic [43:0]  req_addr;
    logic [3:0]   req_snoop;
    logic [2:0]   req_prot;
    logic         acvalid;
    logic         acready;
    logic [43:0]  acaddr;
    logic [3:0]   acsnoop;
    logic [2:0]   acprot;
    logic         crvalid;
    logic         crready;
    logic [4:0]   crresp;
    logic         cdvalid;
    logic         cdready;
    logic [127:0] cddata;
    logic         cdlast;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [4:0]   rsp_crresp;
    logic [511:0] rsp_data;
    logic         rsp_has_data;
    logic [1:0]   rsp_err;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk_100MHz = ~clk_100MHz;

    ace_snoop_initiator #(
        .ADDR_WIDTH    (44),
        .CD_DATA_WIDTH (128),
        .LINE_BEATS    (4),
        .TIMEOUT       (16)
    ) dut (
        .clk_100MHz   (clk_100MHz),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_snoop    (req_snoop),
        .req_prot     (req_prot),
        .acvalid      (acvalid),
        .acready      (acready),
        .acaddr       (acaddr),
        .acsnoop      (acsnoop),
        .acprot       (acprot),
        .crvalid      (crvalid),
        .crready      (crready),
        .crresp       (crresp),
        .cdvalid      (cdvalid),
        .cdready      (cdready),
        .cddata       (cddata),
        .cdlast       (cdlast),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_crresp   (rsp_crresp),
        .rsp_data     (rsp_data),
        .rsp_has_data (rsp_has_data),
        .rsp_err      (rsp_err),
        .busy         (busy)
    );

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk_100MHz);
        #1;
    endtask

    function automatic logic [127:0] beat(input int i);
        return 128'h0123_4567_89AB_CDEF_0000_0000_0000_0000 + 128'(i + 1);
    endfunction

    task automatic drive_req(input logic [43:0] a, input logic [3:0] s, input logic [2:0] p);
        req_valid = 1'b1;
        req_addr  = a;
        req_snoop = s;
        req_prot  = p;
    endtask

    task automatic consume_rsp();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #12;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_req_ready got=%0h exp=1", req_ready); end
        checks++; if ({acvalid, crready, cdready, rsp_valid, busy} !== 5'b0) begin failures++; $display("FAIL rst_handshakes got=%b exp=00000", {acvalid, crready, cdready, rsp_valid, busy}); end
        checks++; if ({acaddr, acsnoop, acprot} !== 51'h0) begin failures++; $display("FAIL rst_ac_payload got=%h exp=0", {acaddr, acsnoop, acprot}); end
        checks++; if ({rsp_crresp, rsp_has_data, rsp_err} !== 8'h0 || rsp_data !== 512'h0) begin failures++; $display("FAIL rst_rsp got=%h exp=0", {rsp_crresp, rsp_has_data, rsp_err}); end
        @(posedge clk_100MHz);
        #1;
        reset = 1'b0;
        step();
    endtask

    task automatic test_read_once();
        drive_req(44'h002, 4'b0000, 3'b010);
        step();
        req_valid = 1'b0;
        checks++; if (acvalid !== 1'b1 || req_ready !== 1'b0) begin failures++; $display("FAIL ro_acvalid got=%b%b exp=10", acvalid, req_ready); end
        checks++; if (acaddr !== 44'h002 || acsnoop !== 4'b0000 || acprot !== 3'b010) begin failures++; $display("FAIL ro_payload got=%h/%h/%h exp=002/0/2", acaddr, acsnoop, acprot); end
        step();
        checks++; if (acvalid !== 1'b0 || crready !== 1'b1) begin failures++; $display("FAIL ro_crready got=%b%b exp=01", acvalid, crready); end
        crvalid = 1'b1;
        crresp  = 5'b00000;
        step();
        crvalid = 1'b0;
        checks++; if (rsp_valid !== 1'b1 || crready !== 1'b0) begin failures++; $display("FAIL ro_rsp_valid got=%b%b exp=10", rsp_valid, crready); end
        checks++; if (rsp_crresp !== 5'b0 || rsp_has_data !== 1'b0 || rsp_err !== 2'd0) begin failures++; $display("FAIL ro_rsp_fields got=%b/%b/%0d exp=00000/0/0", rsp_crresp, rsp_has_data, rsp_err); end
        consume_rsp();
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL ro_idle got=%b%b%b exp=010", rsp_valid, req_ready, busy); end
    endtask

    task automatic test_read_shared_line();
        logic [511:0] exp_line;
        exp_line = {beat(3), beat(2), beat(1), beat(0)};
        drive_req(44'h040, 4'b0001, 3'b000);
        step();
        req_valid = 1'b0;
        step();
        crvalid = 1'b1;
        crresp  = 5'b01001;
        step();
        crvalid = 1'b0;
        checks++; if (cdready !== 1'b1 || crready !== 1'b0) begin failures++; $display("FAIL rs_cdready got=%b%b exp=10", cdready, crready); end
        for (int i = 0; i < 4; i++) begin
            cdvalid = 1'b1;
            cddata  = beat(i);
            cdlast  = (i == 3);
            step();
        end
        cdvalid = 1'b0;
        cdlast  = 1'b0;
        checks++; if (rsp_valid !== 1'b1 || cdready !== 1'b0) begin failures++; $display("FAIL rs_rsp_valid got=%b%b exp=10", rsp_valid, cdready); end
        checks++; if (rsp_data !== exp_line) begin failures++; $display("FAIL rs_line got=%h exp=%h", rsp_data, exp_line); end
        checks++; if (rsp_crresp !== 5'b01001 || rsp_has_data !== 1'b1 || rsp_err !== 2'd0) begin failures++; $display("FAIL rs_fields got=%b/%b/%0d exp=01001/1/0", rsp_crresp, rsp_has_data, rsp_err); end
        consume_rsp();
    endtask

    task automatic test_ac_stall();
        acready = 1'b0;
        drive_req(44'hABC_DEF0_1234, 4'b0010, 3'b101);
        step();
        req_valid = 1'b0;
        req_addr  = 44'h0;
        req_snoop = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            checks++; if (acvalid !== 1'b1 || acaddr !== 44'hABC_DEF0_1234 || acsnoop !== 4'b0010) begin failures++; $display("FAIL stall_cyc%0d got=%b/%h/%h exp=1/abcdef01234/2", i, acvalid, acaddr, acsnoop); end
            step();
        end
        acready = 1'b1;
        step();
        checks++; if (acvalid !== 1'b0 || crready !== 1'b1) begin failures++; $display("FAIL stall_release got=%b%b exp=01", acvalid, crready); end
        crvalid = 1'b1;
        crresp  = 5'b10000;
        step();
        crvalid = 1'b0;
        checks++; if (rsp_valid !== 1'b1 || rsp_crresp !== 5'b10000 || rsp_err !== 2'd0) begin failures++; $display("FAIL stall_rsp got=%b/%b/%0d exp=1/10000/0", rsp_valid, rsp_crresp, rsp_err); end
        consume_rsp();
    endtask

    task automatic test_timeout();
        int high_cycles;
        high_cycles = 0;
        drive_req(44'h080, 4'b0111, 3'b000);
        step();
        req_valid = 1'b0;
        step();
        cdvalid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (crready === 1'b1) high_cycles++;
            step();
        end
        cdvalid = 1'b0;
        checks++; if (high_cycles !== 16) begin failures++; $display("FAIL to_crready_cycles got=%0d exp=16", high_cycles); end
        checks++; if (crready !== 1'b0 || rsp_valid !== 1'b1) begin failures++; $display("FAIL to_abort got=%b%b exp=01", crready, rsp_valid); end
        checks++; if (rsp_err !== 2'd1 || rsp_crresp !== 5'b0 || rsp_has_data !== 1'b0) begin failures++; $display("FAIL to_fields got=%0d/%b/%b exp=1/00000/0", rsp_err, rsp_crresp, rsp_has_data); end
        consume_rsp();
        drive_req(44'h0C4, 4'b1101, 3'b000);
        step();
        req_valid = 1'b0;
        checks++; if (acvalid !== 1'b1 || acsnoop !== 4'b1101) begin failures++; $display("FAIL to_next_req got=%b/%h exp=1/d", acvalid, acsnoop); end
        step();
        crvalid = 1'b1;
        crresp  = 5'b00000;
        step();
        crvalid = 1'b0;
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== 2'd0) begin failures++; $display("FAIL to_next_rsp got=%b/%0d exp=1/0", rsp_valid, rsp_err); end
        consume_rsp();
    endtask

    task automatic test_cdlast_early();
        logic [511:0] exp_line;
        exp_line = '0;
        exp_line[127:0]   = beat(0);
        exp_line[255:128] = beat(1);
        drive_req(44'h0C0, 4'b0001, 3'b000);
        step();
        req_valid = 1'b0;
        step();
        crvalid = 1'b1;
        crresp  = 5'b00001;
        step();
        crvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cdvalid = 1'b1;
            cddata  = beat(i);
            cdlast  = (i == 1);
            step();
        end
        cdvalid = 1'b0;
        cdlast  = 1'b0;
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== 2'd2 || rsp_has_data !== 1'b1) begin failures++; $display("FAIL early_fields got=%b/%0d/%b exp=1/2/1", rsp_valid, rsp_err, rsp_has_data); end
        checks++; if (rsp_data !== exp_line) begin failures++; $display("FAIL early_line got=%h exp=%h", rsp_data, exp_line); end
        consume_rsp();
    endtask

    task automatic test_reset_mid();
        drive_req(44'h100, 4'b0001, 3'b001);
        step();
        req_valid = 1'b0;
        step();
        crvalid = 1'b1;
        crresp  = 5'b00001;
        step();
        crvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cdvalid = 1'b1;
            cddata  = beat(i);
            cdlast  = 1'b0;
            step();
        end
        cddata = beat(2);
        reset  = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b1 || {acvalid, crready, cdready, rsp_valid, busy} !== 5'b0) begin failures++; $display("FAIL mid_rst_ctrl got=%b/%b exp=1/00000", req_ready, {acvalid, crready, cdready, rsp_valid, busy}); end
        checks++; if (rsp_data !== 512'h0 || acaddr !== 44'h0 || rsp_crresp !== 5'b0) begin failures++; $display("FAIL mid_rst_data got=%h/%h exp=0/0", acaddr, rsp_crresp); end
        cdvalid = 1'b0;
        #3;
        reset = 1'b0;
        step();
        drive_req(44'h200, 4'b1001, 3'b000);
        step();
        req_valid = 1'b0;
        checks++; if (acvalid !== 1'b1 || acsnoop !== 4'b1001 || acaddr !== 44'h200) begin failures++; $display("FAIL mid_ci_ac got=%b/%h/%h exp=1/9/200", acvalid, acsnoop, acaddr); end
        step();
        crvalid = 1'b1;
        crresp  = 5'b00000;
        step();
        crvalid = 1'b0;
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== 2'd0 || rsp_has_data !== 1'b0) begin failures++; $display("FAIL mid_ci_rsp got=%b/%0d/%b exp=1/0/0", rsp_valid, rsp_err, rsp_has_data); end
        consume_rsp();
    endtask

    initial begin
        req_valid = 1'b0;
        req_addr  = '0;
        req_snoop = '0;
        req_prot  = '0;
        acready   = 1'b1;
        crvalid   = 1'b0;
        crresp    = '0;
        cdvalid   = 1'b0;
        cddata    = '0;
        cdlast    = 1'b0;
        rsp_ready = 1'b0;
        test_reset();
        test_read_once();
        test_read_shared_line();
        test_ac_stall();
        test_timeout();
        test_cdlast_early();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
